// File: rtl/syn_pkg.sv
// Shared types and helpers for the syn transfer arbiter.
package syn_pkg;

    localparam int unsigned DW_DEF   = 4;
    localparam int unsigned NREQ_MAX = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        REL  = 2'd2
    } state_t;

    // One-hot pick of the first set bit at or after ptr, wrapping within n bits.
    function automatic logic [NREQ_MAX-1:0] rr_pick(input logic [NREQ_MAX-1:0] req,
                                                    input logic [2:0]          ptr,
                                                    input int unsigned         n);
        logic [NREQ_MAX-1:0] g;
        logic                found;
        int unsigned         j;
        g     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ_MAX; i++) begin
            j = (32'(ptr) + i) % n;
            if (i < n && !found && req[j[2:0]]) begin
                g[j[2:0]] = 1'b1;
                found     = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/syn_xfer_arb_if.sv
// Requester and channel signals of the syn transfer arbiter.
interface syn_xfer_arb_if import syn_pkg::*; #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = DW_DEF
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    done;
    logic [NREQ-1:0]    err;
    logic               xfer_valid;
    logic [DW-1:0]      xfer_data;
    logic               xfer_ack;
    logic               busy;

    // Arbiter side.
    modport slave (
        input  req, req_data, xfer_ack,
        output grant, done, err, xfer_valid, xfer_data, busy
    );

    // Requester / channel side.
    modport master (
        output req, req_data, xfer_ack,
        input  grant, done, err, xfer_valid, xfer_data, busy
    );
endinterface

// File: rtl/rr_arb.sv
// Combinational round-robin picker: one-hot grant and its index.
module rr_arb import syn_pkg::*; #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt_c,
    output logic [PW-1:0]   idx_c,
    output logic            any_c
);
    logic [NREQ_MAX-1:0] pick8;
    logic                unused_pick;

    assign pick8       = rr_pick(NREQ_MAX'(req), 3'(ptr), NREQ);
    assign gnt_c       = pick8[NREQ-1:0];
    assign any_c       = |req;
    assign unused_pick = ^pick8;

    // Encode the one-hot pick into an index.
    always_comb begin
        idx_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick8[i]) idx_c = PW'(i);
        end
    end
endmodule

// File: rtl/syn_xfer_arb.sv
// Shares the syn crossing channel between NREQ requesters with a 4-phase handshake.
module syn_xfer_arb import syn_pkg::*; #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    syn_xfer_arb_if.slave bus
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [NREQ-1:0] err_q, err_d;
    logic            valid_q, valid_d;
    logic [DW-1:0]   data_q, data_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;

    logic [NREQ-1:0] gnt_c;
    logic [PW-1:0]   idx_c;
    logic            any_c;

    rr_arb #(.NREQ(NREQ), .PW(PW)) u_rr (
        .req   (bus.req),
        .ptr   (ptr_q),
        .gnt_c (gnt_c),
        .idx_c (idx_c),
        .any_c (any_c)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state: grant in IDLE, wait for ack or timeout in SEND, drain ack in REL.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        err_d   = '0;
        valid_d = valid_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_c && !bus.xfer_ack) begin
                    grant_d = gnt_c;
                    data_d  = bus.req_data[idx_c*DW +: DW];
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    ptr_d   = (idx_c == PW'(NREQ - 1)) ? '0 : idx_c + PW'(1);
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.xfer_ack) begin
                    valid_d = 1'b0;
                    done_d  = grant_q;
                    state_d = REL;
                end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1)) begin
                    valid_d = 1'b0;
                    err_d   = grant_q;
                    state_d = REL;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            REL: begin
                if (!bus.xfer_ack) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign bus.grant      = grant_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.xfer_valid = valid_q;
    assign bus.xfer_data  = data_q;
    assign bus.busy       = busy_q;
endmodule
